// File: rtl/instr_encode_loader.sv
// Field-level RV32I instruction encoder that streams encoded words into imem.
// Define INSTR_ENC_ADDI_EN to accept op_sel=5 as ADDI; otherwise it is illegal.
module instr_encode_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [12:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              full,
  output logic              illegal_err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic {RUN, FULL} state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic [ADDR_W:0]   count_next;
  logic              err_next;
  logic [31:0]       word;
  logic              legal;
  logic              imm_fits;
  logic              accept;
  logic              write;

  assign in_ready   = (state == RUN) && !clear;
  assign full       = (state == FULL);
  assign accept     = in_valid && in_ready;
  assign write      = accept && legal;
  assign imm_fits   = (imm[12] == imm[11]);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value unassigned and infer a latch.
  always_comb begin
    word  = '0;
    legal = 1'b0;
    unique case (op_sel)
      3'd0: begin
        word  = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
        legal = 1'b1;
      end
      3'd1: begin
        word  = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
        legal = 1'b1;
      end
      3'd2: begin
        word  = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
        legal = imm_fits;
      end
      3'd3: begin
        word  = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
        legal = imm_fits;
      end
      3'd4: begin
        word  = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
        legal = !imm[0];
      end
`ifdef INSTR_ENC_ADDI_EN
      3'd5: begin
        word  = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
        legal = imm_fits;
      end
`endif
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  // Clear overrides everything; a write registered last cycle still drains.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    count_next = word_count;
    err_next   = illegal_err;
    if (clear) begin
      state_next = RUN;
      ptr_next   = BASE;
      count_next = '0;
      err_next   = 1'b0;
    end else if (accept) begin
      if (legal) begin
        count_next = word_count + (ADDR_W+1)'(1);
        if (ptr == LAST) state_next = FULL;
        else             ptr_next   = ptr + ADDR_W'(1);
      end else begin
        err_next = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      ptr         <= BASE;
      word_count  <= '0;
      illegal_err <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= BASE;
      imem_wdata  <= '0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      word_count  <= count_next;
      illegal_err <= err_next;
      imem_we     <= write;
      if (write) begin
        imem_addr  <= ptr;
        imem_wdata <= word;
      end
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench: directed steps then random traffic against a field-level
// reference model, on a 256-word instance and a 4-word instance side by side.
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        valid_b = 1'b0, valid_s = 1'b0;
  logic [2:0]  op_sel = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [12:0] imm = '0;

  logic        ready_b, we_b, full_b, err_b;
  logic [7:0]  addr_b;
  logic [31:0] wdata_b;
  logic [8:0]  cnt_b;
  logic        ready_s, we_s, full_s, err_s;
  logic [1:0]  addr_s;
  logic [31:0] wdata_s;
  logic [2:0]  cnt_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_encode_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(valid_b), .in_ready(ready_b),
    .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
    .full(full_b), .illegal_err(err_b), .word_count(cnt_b)
  );

  instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(valid_s), .in_ready(ready_s),
    .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(we_s), .imem_addr(addr_s), .imem_wdata(wdata_s),
    .full(full_s), .illegal_err(err_s), .word_count(cnt_s)
  );

  // Reference model state, index 0 = 256-word instance, 1 = 4-word instance.
  int          depth [2] = '{256, 4};
  int          m_ptr [2], m_cnt [2], m_addr [2];
  bit          m_full [2], m_err [2], m_we [2];
  logic [31:0] m_wdata [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void encode(output bit legal, output logic [31:0] w);
    int iv, u12, b, r1, r2, d, x;
    bit fits;
    iv   = imm[12] ? int'(imm) - 8192 : int'(imm);
    fits = (iv >= -2048) && (iv <= 2047);
    u12  = iv & 'hfff;
    b    = iv & 'h1fff;
    r1   = int'(rs1);
    r2   = int'(rs2);
    d    = int'(rd);
    legal = 1'b0;
    x     = 0;
    case (op_sel)
      3'd0: begin x = (r2 << 20) | (r1 << 15) | (d << 7) | 'h33; legal = 1'b1; end
      3'd1: begin x = 'h40000000 | (r2 << 20) | (r1 << 15) | (d << 7) | 'h33; legal = 1'b1; end
      3'd2: begin x = (u12 << 20) | (r1 << 15) | (2 << 12) | (d << 7) | 'h03; legal = fits; end
      3'd3: begin
        x = ((u12 >> 5) << 25) | (r2 << 20) | (r1 << 15) | (2 << 12) | ((u12 & 31) << 7) | 'h23;
        legal = fits;
      end
      3'd4: begin
        x = (((b >> 12) & 1) << 31) | (((b >> 5) & 'h3f) << 25) | (r2 << 20) | (r1 << 15)
          | (((b >> 1) & 'hf) << 8) | (((b >> 11) & 1) << 7) | 'h63;
        legal = ((iv & 1) == 0);
      end
`ifdef INSTR_ENC_ADDI_EN
      3'd5: begin x = (u12 << 20) | (r1 << 15) | (d << 7) | 'h13; legal = fits; end
`endif
      default: legal = 1'b0;
    endcase
    w = 32'(x);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0; m_cnt[i] = 0; m_addr[i] = 0;
      m_full[i] = 0; m_err[i] = 0; m_we[i] = 0; m_wdata[i] = '0;
    end
  endfunction

  function automatic void model_step(input int i, input bit v);
    bit          legal;
    logic [31:0] w;
    encode(legal, w);
    m_we[i] = 1'b0;
    if (clear) begin
      m_ptr[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_full[i] = 0;
    end else if (v && !m_full[i]) begin
      if (legal) begin
        m_we[i] = 1'b1; m_addr[i] = m_ptr[i]; m_wdata[i] = w; m_cnt[i]++;
        if (m_ptr[i] == depth[i] - 1) m_full[i] = 1'b1;
        else m_ptr[i]++;
      end else begin
        m_err[i] = 1'b1;
      end
    end
  endfunction

  task automatic cmp_inst(input int i, input logic we, input logic [7:0] addr, input logic [31:0] wd,
                          input logic fl, input logic er, input logic [8:0] cnt, input logic rdy);
    string p;
    p = (i == 0) ? "big" : "small";
    check({p, ".imem_we"}, 32'(we), 32'(m_we[i]));
    check({p, ".imem_addr"}, 32'(addr), 32'(m_addr[i]));
    check({p, ".imem_wdata"}, wd, m_wdata[i]);
    check({p, ".full"}, 32'(fl), 32'(m_full[i]));
    check({p, ".illegal_err"}, 32'(er), 32'(m_err[i]));
    check({p, ".word_count"}, 32'(cnt), 32'(m_cnt[i]));
    check({p, ".in_ready"}, 32'(rdy), 32'(!m_full[i] && !clear));
  endtask

  task automatic compare_all();
    cmp_inst(0, we_b, addr_b, wdata_b, full_b, err_b, cnt_b, ready_b);
    cmp_inst(1, we_s, {6'b0, addr_s}, wdata_s, full_s, err_s, {6'b0, cnt_s}, ready_s);
  endtask

  task automatic drive(input logic [2:0] o, input logic [4:0] d, input logic [4:0] a,
                       input logic [4:0] b, input logic [12:0] im,
                       input logic vb, input logic vs, input logic clr);
    op_sel = o; rd = d; rs1 = a; rs2 = b; imm = im;
    valid_b = vb; valid_s = vs; clear = clr;
  endtask

  // Inputs change at negedge; model advances at posedge; outputs checked at negedge.
  task automatic tick();
    @(posedge clk);
    model_step(0, valid_b);
    model_step(1, valid_s);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();

    rst_n = 1'b1;
    drive(3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check("add_word", wdata_b, 32'h002081B3);
    check("add_we", 32'(we_b), 32'd1);
    check("add_count", 32'(cnt_b), 32'd1);

    drive(3'd0, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(3'd1, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check("sub_word", wdata_b, 32'h402081B3);
    check("sub_addr", 32'(addr_b), 32'd0);
    drive(3'd2, 5'd5, 5'd2, 5'd0, 13'd8, 1'b1, 1'b0, 1'b0);
    tick();
    check("lw_word", wdata_b, 32'h00812283);
    check("lw_ready", 32'(ready_b), 32'd1);
    drive(3'd3, 5'd0, 5'd2, 5'd5, 13'd8, 1'b1, 1'b0, 1'b0);
    tick();
    check("sw_word", wdata_b, 32'h00512423);
    drive(3'd4, 5'd0, 5'd1, 5'd2, 13'd8, 1'b1, 1'b0, 1'b0);
    tick();
    check("beq_word", wdata_b, 32'h00208463);
    check("beq_addr", 32'(addr_b), 32'd3);

    drive(3'd2, 5'd5, 5'd2, 5'd0, 13'h0800, 1'b1, 1'b0, 1'b0);
    tick();
    check("lw_range_we", 32'(we_b), 32'd0);
    check("lw_range_err", 32'(err_b), 32'd1);
    drive(3'd4, 5'd0, 5'd1, 5'd2, 13'd7, 1'b1, 1'b0, 1'b0);
    tick();
    check("beq_odd_we", 32'(we_b), 32'd0);
    check("illegal_count", 32'(cnt_b), 32'd4);
    drive(3'd0, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check("clear_err", 32'(err_b), 32'd0);

    for (int k = 0; k < 4; k++) begin
      drive(3'd0, 5'(k + 1), 5'd1, 5'd2, 13'd0, 1'b0, 1'b1, 1'b0);
      tick();
      check($sformatf("fill_addr%0d", k), 32'(addr_s), 32'(k));
    end
    check("fill_full", 32'(full_s), 32'd1);
    check("fill_ready", 32'(ready_s), 32'd0);
    tick();
    check("held_off_we", 32'(we_s), 32'd0);
    drive(3'd0, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(3'd0, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("refill_ready", 32'(ready_s), 32'd1);
    drive(3'd0, 5'd7, 5'd1, 5'd2, 13'd0, 1'b0, 1'b1, 1'b0);
    tick();
    check("refill_addr", 32'(addr_s), 32'd0);

    drive(3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_we", 32'(we_b), 32'd0);
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    drive(3'd5, 5'd1, 5'd0, 5'd0, 13'h1FFF, 1'b1, 1'b0, 1'b0);
    tick();
`ifdef INSTR_ENC_ADDI_EN
    check("addi_word", wdata_b, 32'hFFF00093);
    check("addi_we", 32'(we_b), 32'd1);
`else
    check("addi_err", 32'(err_b), 32'd1);
    check("addi_we", 32'(we_b), 32'd0);
`endif

    for (int n = 0; n < 400; n++) begin
      logic [12:0] im;
      logic [10:0] small_imm;
      small_imm = 11'($urandom);
      im = ($urandom_range(0, 3) == 0) ? 13'($urandom) : {{2{small_imm[10]}}, small_imm};
      drive(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), im,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
